// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master blocks: controller states, SPI mode
// constants and the default divider and word-width settings.
package spi_pkg;

  localparam int   SPI_CLK_DIV = 4;
  localparam int   SPI_DATA_W  = 8;
  localparam logic SPI_CPOL    = 1'b0;
  localparam logic SPI_CPHA    = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD,
    ST_END,
    ST_GAP
  } spi_state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator. Toggles sclk every CLK_DIV clk cycles while enabled and
// flags the clk cycle right before each sclk edge with a rise or fall strobe.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          wrap;

  assign wrap = en && (cnt_q == CW'(CLK_DIV - 1));

  // The strobes are combinational so the controller acts on the same clk
  // edge that moves sclk.
  assign rise = wrap && (sclk_q == SPI_CPOL);
  assign fall = wrap && (sclk_q != SPI_CPOL);
  assign sclk = sclk_q;

  // NOTE: give every always_comb output a default first so no path leaves it
  // unassigned; that is what keeps latches from being inferred.
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en) begin
      cnt_d  = '0;
      sclk_d = SPI_CPOL;
    end else if (wrap) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, whatever order the blocks happen to run in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      sclk_q <= SPI_CPOL;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Word-level SPI master, mode 0, MSB first. Words arrive over valid/ready;
// words not marked last are chained into one burst with cs_n held low.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV,
  parameter int DATA_W  = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_last,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int DW = $clog2(CLK_DIV + 1);

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              last_q, last_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]     dly_q, dly_d;
  logic              tx_ready_q, tx_ready_d;
  logic              cs_n_q, cs_n_d;

  logic sclk_rise, sclk_fall;
  logic sample_edge, shift_edge;
  logic accept, last_fall, dly_done;

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == ST_SHIFT),
    .sclk  (sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  assign sample_edge = (SPI_CPHA == 1'b0) ? sclk_rise : sclk_fall;
  assign shift_edge  = (SPI_CPHA == 1'b0) ? sclk_fall : sclk_rise;
  assign accept      = tx_valid && tx_ready_q;
  assign last_fall   = shift_edge && (bit_cnt_q == BW'(DATA_W - 1));
  assign dly_done    = (dly_q == DW'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept)    state_d = ST_SHIFT;
      ST_SHIFT: if (last_fall) state_d = last_q ? ST_END : ST_HOLD;
      ST_HOLD:  if (accept)    state_d = ST_SHIFT;
      ST_END:   if (dly_done)  state_d = ST_GAP;
      ST_GAP:   if (dly_done)  state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    last_d     = last_q;
    bit_cnt_d  = bit_cnt_q;
    dly_d      = dly_q + DW'(1);

    if (accept) begin
      tx_sh_d = tx_data;
      last_d  = tx_last;
    end

    if (state_q == ST_SHIFT) begin
      if (sample_edge) rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
      if (shift_edge) begin
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (last_fall) begin
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
        end else begin
          tx_sh_d = tx_sh_q << 1;
        end
      end
    end

    // Counters restart on every state entry, including HOLD -> SHIFT.
    if (state_d != state_q) begin
      bit_cnt_d = '0;
      dly_d     = '0;
    end
    if (state_d == ST_IDLE) tx_sh_d = '0;

    tx_ready_d = (state_d == ST_IDLE) || (state_d == ST_HOLD);
    cs_n_d     = (state_d == ST_IDLE) || (state_d == ST_GAP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      last_q     <= 1'b0;
      bit_cnt_q  <= '0;
      dly_q      <= '0;
      tx_ready_q <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      last_q     <= last_d;
      bit_cnt_q  <= bit_cnt_d;
      dly_q      <= dly_d;
      tx_ready_q <= tx_ready_d;
      cs_n_q     <= cs_n_d;
    end
  end

  // mosi is the shift register MSB, so it holds the last bit after the word.
  assign mosi     = tx_sh_q[DATA_W-1];
  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign cs_n     = cs_n_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: loopback and slave-model transfers with a
// scoreboard of expected received words, plus cycle-exact timing of one word.
module tb_spi_master_ctrl;

  localparam int CLK_DIV = 2;
  localparam int DATA_W  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_last = 1'b0;
  logic              tx_valid = 1'b0;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;

  logic              loop_en = 1'b1;
  logic [7:0]        slave_tx = '0;
  logic [7:0]        slave_rx = '0;
  int                slave_idx = 0;

  int                checks = 0;
  int                errors = 0;
  logic [7:0]        sb_q[$];
  int                rx_cnt = 0;
  int                cs_rise_cnt = 0;
  logic              cs_prev = 1'b1;

  spi_master_ctrl #(
    .CLK_DIV (CLK_DIV),
    .DATA_W  (DATA_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso)
  );

  always #5 clk = ~clk;

  // Mode-0 slave: samples mosi on sclk rise, advances its bit on sclk fall.
  always @(posedge sclk) slave_rx <= {slave_rx[6:0], mosi};
  always @(negedge sclk or posedge cs_n) begin
    if (cs_n) slave_idx <= 0;
    else      slave_idx <= slave_idx + 1;
  end
  assign miso = loop_en ? mosi : ((slave_idx < 8) ? slave_tx[7 - slave_idx] : 1'b0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cs_n && !cs_prev) cs_rise_cnt++;
    cs_prev = cs_n;
    if (rx_valid) begin
      rx_cnt++;
      checks++;
      assert (sb_q.size() != 0)
      else begin
        errors++;
        $error("FAIL rx_unexpected: observed rx_data %0h expected no rx_valid", rx_data);
      end
      if (sb_q.size() != 0) check("rx_data", rx_data, sb_q.pop_front());
    end
  end

  // Called at a falling clk edge; returns at the falling edge after acceptance.
  task automatic send(input logic [7:0] d, input logic l, input bit exp_loop);
    int i = 0;
    while (!tx_ready && i < 500) begin
      @(negedge clk);
      i++;
    end
    check("send_ready", tx_ready, 1'b1);
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    if (exp_loop) sb_q.push_back(d);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i = 0;
    while ((busy || sb_q.size() != 0) && i < 1000) begin
      @(negedge clk);
      i++;
    end
    check("idle_busy", busy, 1'b0);
    check("idle_sb_empty", sb_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   rise_cyc[8];
    int   rise_cnt, rxv_cyc, csh_cyc, rdy_cyc, rx_base;
    logic prev_sclk;

    // Reset held for three cycles.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_ready", tx_ready, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sclk", sclk, 1'b0);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_mosi", mosi, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_tx_ready", tx_ready, 1'b1);
    check("post_rst_cs_n", cs_n, 1'b1);

    // Single word, loopback, cycle-exact timing.
    send(8'hA5, 1'b1, 1'b1);
    rise_cnt  = 0;
    rxv_cyc   = -1;
    csh_cyc   = -1;
    rdy_cyc   = -1;
    prev_sclk = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) @(negedge clk);
      if (n == 1) check("single_cs_fall", cs_n, 1'b0);
      if (sclk && !prev_sclk) begin
        if (rise_cnt < 8) rise_cyc[rise_cnt] = n;
        rise_cnt++;
      end
      prev_sclk = sclk;
      if (rx_valid && rxv_cyc < 0) rxv_cyc = n;
      if (n > 1 && cs_n && csh_cyc < 0) csh_cyc = n;
      if (tx_ready && rdy_cyc < 0) rdy_cyc = n;
    end
    check("single_rise_count", rise_cnt, 8);
    for (int k = 0; k < 8; k++) check($sformatf("single_rise_%0d", k), rise_cyc[k], 3 + 4 * k);
    check("single_rx_valid_cyc", rxv_cyc, 33);
    check("single_cs_rise_cyc", csh_cyc, 35);
    check("single_tx_ready_cyc", rdy_cyc, 37);
    wait_idle();

    // Burst of two words; the second is accepted in the first HOLD cycle.
    rx_base     = rx_cnt;
    cs_rise_cnt = 0;
    send(8'h3C, 1'b0, 1'b1);
    send(8'hC3, 1'b1, 1'b1);
    check("burst_cs_low", cs_n, 1'b0);
    @(negedge clk);
    check("burst_sclk_c35", sclk, 1'b0);
    @(negedge clk);
    check("burst_sclk_c36", sclk, 1'b1);
    wait_idle();
    check("burst_rx_count", rx_cnt - rx_base, 2);
    check("burst_cs_rises", cs_rise_cnt, 1);

    // Against the slave model.
    loop_en  = 1'b0;
    slave_tx = 8'h5A;
    sb_q.push_back(8'h5A);
    send(8'hAA, 1'b1, 1'b0);
    wait_idle();
    check("slave_captured", slave_rx, 8'hAA);
    loop_en = 1'b1;

    // Reset in the middle of a word.
    rx_base = rx_cnt;
    send(8'h66, 1'b1, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_cs_n", cs_n, 1'b1);
    check("midrst_sclk", sclk, 1'b0);
    check("midrst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_no_rx", rx_cnt - rx_base, 0);
    send(8'h81, 1'b1, 1'b1);
    wait_idle();

    // tx_valid held high through SHIFT/END/GAP must not be taken again.
    rx_base = rx_cnt;
    send(8'hFF, 1'b1, 1'b1);
    tx_valid = 1'b1;
    begin
      int i = 0;
      while (!tx_ready && i < 500) begin
        @(negedge clk);
        i++;
      end
    end
    tx_valid = 1'b0;
    check("ignored_rx_count", rx_cnt - rx_base, 1);
    repeat (20) @(negedge clk);
    check("ignored_busy", busy, 1'b0);
    check("ignored_rx_after", rx_cnt - rx_base, 1);
    check("ignored_sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Byte-level SPI master front end that feeds the team's shift-register SPI master/slave pair. It accepts words over a valid/ready interface, generates `sclk` and `cs_n` from `clk` with a programmable divider, and shifts `mosi` out MSB-first in SPI mode 0. It samples `miso` and returns each received word with a one-cycle valid strobe. Back-to-back words marked as not-last are sent as one burst with `cs_n` held low.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per `sclk` half-period. Must be ≥1.
- `DATA_W`, default 8: bits per word. Must be ≥2.
- `clk`  in  1  system clock. All logic is on its rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `tx_data`  in  DATA_W  word to transmit. Captured on accept.
- `tx_last`  in  1  end of burst after this word. Captured on accept.
- `tx_valid`  in  1  `tx_data`/`tx_last` are valid.
- `tx_ready`  out  1  registered. High only in IDLE or HOLD.
- `rx_data`  out  DATA_W  last received word. Holds its value until the next word completes.
- `rx_valid`  out  1  one-cycle pulse. No backpressure.
- `busy`  out  1  high in any state other than IDLE.
- `sclk`  out  1  SPI clock. Idles low (CPOL=0).
- `cs_n`  out  1  chip select, active-low.
- `mosi`  out  1  serial data out.
- `miso`  in  1  serial data in. Already synchronous to `clk`.

## Operation
- Reset values: `tx_ready`=0, `rx_data`=0, `rx_valid`=0, `busy`=0, `sclk`=0, `cs_n`=1, `mosi`=0, state=IDLE. After reset is released, `tx_ready` rises on the first `clk` edge.
- Accept rule: a word is accepted on a `clk` edge where `tx_valid`&&`tx_ready`. When `tx_ready`=0, `tx_valid` is ignored and the data is not sampled.
- The FSM states are IDLE, SHIFT, HOLD, END and GAP.
- **IDLE**
  - `cs_n`=1, `sclk`=0, `mosi`=0.
  - On accept, load the shift register and go to SHIFT.
- **SHIFT**
  - `cs_n`=0 and `mosi`=MSB from the first SHIFT cycle.
  - The half-period counter toggles `sclk` every `CLK_DIV` cycles.
  - On the edge that raises `sclk`, sample `miso` into the receive register LSB (shift left).
  - On the edge that lowers `sclk`, shift `mosi` to the next bit.
  - After the `DATA_W`-th falling edge:
    - update `rx_data` and pulse `rx_valid`;
    - `mosi` holds its last bit;
    - go to HOLD if captured `tx_last`=0, else to END.
- **HOLD**
  - `cs_n`=0, `sclk`=0, `tx_ready`=1.
  - Waits indefinitely. On accept, go to SHIFT with `mosi`=new MSB on the next cycle, keeping `cs_n` low.
- **END**: `cs_n`=0 for `CLK_DIV` cycles (CS hold time), then go to GAP.
- **GAP**: `cs_n`=1 and `tx_ready`=0 for `CLK_DIV` cycles (minimum deselect time), then go to IDLE.
- Counter rules:
  - Half-period counter is `$clog2(CLK_DIV+1)` bits and wraps at `CLK_DIV`-1.
  - Bit counter is `$clog2(DATA_W+1)` bits.
  - Both counters clear on every state entry.
- Asynchronous reset asserted mid-transfer forces all reset values immediately (`cs_n` high, `sclk` low). The partial word is discarded and no `rx_valid` is produced.

## Timing
- Take the accept edge as cycle 0. Then:
  - `cs_n` falls at cycle 1.
  - `sclk` rises at cycles 1+`CLK_DIV`+2·`CLK_DIV`·k, for k=0..`DATA_W`-1.
  - The final fall is at cycle 1+2·`CLK_DIV`·`DATA_W`, and `rx_valid` is high in that same cycle.
- SHIFT occupies exactly 2·`CLK_DIV`·`DATA_W` cycles per word.
- Example with `CLK_DIV`=2, `DATA_W`=8:
  - `sclk` rises at cycles 3, 7, …, 31;
  - `rx_valid` is high at cycle 33;
  - `cs_n` rises at cycle 35;
  - `tx_ready` is high from cycle 37.
- In a burst, a word accepted in the first HOLD cycle (33) starts SHIFT at cycle 34, and `sclk` next rises at cycle 36.

## Structure
- Shared package `spi_pkg` holds:
  - the state enum (IDLE, SHIFT, HOLD, END, GAP);
  - mode constants (CPOL=0, CPHA=0);
  - the default `CLK_DIV`/`DATA_W` localparams used by the SPI blocks.
- One sub-module, `spi_sclk_gen`, contains:
  - the half-period divider;
  - the `sclk` register;
  - one-cycle `rise`/`fall` strobes.
- It has an `en` input that clears it when low. The FSM and shift registers live in `spi_master_ctrl`.

## Test plan
- **Reset:** assert `reset` for 3 cycles → all outputs at their reset values. Release → `tx_ready`=1 on the next edge, and `cs_n` stays 1.
- **Single word, loopback:** `CLK_DIV`=2, `miso`=`mosi`, send 0xA5 with `tx_last`=1 → `sclk` rises at cycles 3..31, `rx_valid` at cycle 33 with `rx_data`=0xA5, `cs_n` high at cycle 35, `tx_ready` high at cycle 37.
- **Burst:** send 0x3C (`tx_last`=0), then 0xC3 (`tx_last`=1) presented in HOLD → `cs_n` low continuously, `rx_valid` twice, loopback `rx_data` = 0x3C then 0xC3.
- **Against the SPI slave model:** slave preloaded with 0x5A → `rx_data`=0x5A, and the slave captures the transmitted 0xAA.
- **Mid-byte reset:** assert `reset` at cycle 10 of a transfer → `cs_n`=1 and `sclk`=0 immediately, no `rx_valid`. The next transfer of 0x81 returns 0x81.
- **Ignored valid:** hold `tx_valid` with 0xFF during SHIFT/END/GAP → not accepted. It is accepted only when `tx_ready`=1, and exactly one word is sent.
